pulse_train_gen: RTL and testbench

//  Transmit side of the single-clock pulse path: generates a programmable train
//  of pulses (initial delay, high time, low time, repeat count) on a one-bit

---
 rtl/pulse_train_gen_if.sv | 25 ++
 rtl/pulse_train_gen.sv | 111 +++++++++++
 tb/tb_pulse_train_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pulse_train_gen_if.sv
// pulse_train_gen_if: request/config inputs and pulse/status outputs of the pulse train generator
interface pulse_train_gen_if #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] delay_len;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [REP_W-1:0] repeat_cnt;
    logic             pulse_o;
    logic             pulse_d_o;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] rep_idx;
    modport master (
        output start, abort, delay_len, high_len, low_len, repeat_cnt,
        input  pulse_o, pulse_d_o, busy, done, rep_idx
    );
    modport slave (
        input  start, abort, delay_len, high_len, low_len, repeat_cnt,
        output pulse_o, pulse_d_o, busy, done, rep_idx
    );
endinterface

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable pulse train (delay, high, low, repeat) with a delayed copy
module pulse_train_gen #(
    parameter int CNT_W      = 16,
    parameter int REP_W      = 8,
    parameter int PIPE_DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    pulse_train_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    h_q, h_d;
    logic [CNT_W-1:0]    l_q, l_d;
    logic [REP_W-1:0]    last_q, last_d;
    logic [REP_W-1:0]    idx_q, idx_d;
    logic                pulse_q, pulse_d;
    logic                done_q, done_d;
    logic [PIPE_DEPTH-1:0] pipe_q;
    logic [PIPE_DEPTH:0]   pipe_ext;
    logic [CNT_W-1:0]    hm1, lm1;
    // Lengths are stored minus one so a zero length behaves as one cycle
    assign hm1      = (bus.high_len == '0) ? '0 : bus.high_len - 1'b1;
    assign lm1      = (bus.low_len == '0) ? '0 : bus.low_len - 1'b1;
    assign pipe_ext = {pipe_q, pulse_q};
    // State, counters, latched config, pulse and delay-line registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            l_q     <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            l_q     <= l_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            pipe_q  <= pipe_ext[PIPE_DEPTH-1:0];
        end
    end
    // Next-state logic: phase sequencing, counter reloads, abort override
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        l_d     = l_q;
        last_d  = last_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start && !bus.abort) begin
                h_d    = hm1;
                l_d    = lm1;
                last_d = bus.repeat_cnt - 1'b1;
                idx_d  = '0;
                if (bus.repeat_cnt == '0) begin
                    done_d = 1'b1;
                end else if (bus.delay_len == '0) begin
                    state_d = HIGH;
                    cnt_d   = hm1;
                end else begin
                    state_d = DELAY;
                    cnt_d   = bus.delay_len - 1'b1;
                end
            end
            DELAY: begin
                state_d = (cnt_q == '0) ? HIGH : DELAY;
                cnt_d   = (cnt_q == '0) ? h_q : cnt_q - 1'b1;
            end
            HIGH: begin
                state_d = (cnt_q == '0) ? LOW : HIGH;
                cnt_d   = (cnt_q == '0) ? l_q : cnt_q - 1'b1;
            end
            LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (idx_q == last_q) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = HIGH;
                    cnt_d   = h_q;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
        end
        pulse_d = (state_d == HIGH);
    end
    assign bus.pulse_o   = pulse_q;
    assign bus.pulse_d_o = pipe_q[PIPE_DEPTH-1];
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.rep_idx   = idx_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed self-checking bench for pulse_train_gen
module tb_pulse_train_gen;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    pulse_train_gen_if #(.CNT_W(16), .REP_W(8)) bus ();
    pulse_train_gen #(.CNT_W(16), .REP_W(8), .PIPE_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic ep(input int n, input int d, input int h, input int l, input int r);
        return n >= d && n < d + r * (h + l) && ((n - d) % (h + l)) < h;
    endfunction
    task automatic check_train(input string t, input int n, input int d, input int h, input int l, input int r);
        int e;
        e = d + r * (h + l);
        chk($sformatf("%s pulse n=%0d", t, n), 32'(bus.pulse_o), 32'(ep(n, d, h, l, r)));
        chk($sformatf("%s busy n=%0d", t, n), 32'(bus.busy), 32'(n < e));
        chk($sformatf("%s done n=%0d", t, n), 32'(bus.done), 32'(n == e));
        chk($sformatf("%s idx n=%0d", t, n), 32'(bus.rep_idx), (n >= d && n < e) ? 32'((n - d) / (h + l)) : 32'd0);
    endtask
    task automatic cfg(input int d, input int h, input int l, input int r);
        bus.delay_len  = 16'(d);
        bus.high_len   = 16'(h);
        bus.low_len    = 16'(l);
        bus.repeat_cnt = 8'(r);
    endtask
    task automatic chk_zero(input string t);
        chk({t, " pulse"}, 32'(bus.pulse_o), 32'd0);
        chk({t, " pulse_d"}, 32'(bus.pulse_d_o), 32'd0);
        chk({t, " busy"}, 32'(bus.busy), 32'd0);
        chk({t, " done"}, 32'(bus.done), 32'd0);
        chk({t, " idx"}, 32'(bus.rep_idx), 32'd0);
    endtask
    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cfg(0, 0, 0, 0);
        #1 reset = 1'b1;
        #1 chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        // long train; config changed after accept, start pulsed while busy
        cfg(2, 6, 2, 10);
        bus.start = 1'b1;
        for (int n = 0; n <= 85; n++) begin
            @(negedge clk);
            if (n == 0) begin
                bus.start = 1'b0;
                cfg(7, 1, 1, 1);
            end
            if (n == 40) bus.start = 1'b1;
            if (n == 41) bus.start = 1'b0;
            check_train("t1", n, 2, 6, 2, 10);
            chk($sformatf("t1 pulse_d n=%0d", n), 32'(bus.pulse_d_o), n >= 2 ? 32'(ep(n - 2, 2, 6, 2, 10)) : 32'd0);
        end
        // repeat of zero: done only
        cfg(0, 3, 3, 0);
        bus.start = 1'b1;
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_train("t3", n, 0, 3, 3, 0);
            chk($sformatf("t3 pulse_d n=%0d", n), 32'(bus.pulse_d_o), 32'd0);
        end
        // abort and start together in IDLE: nothing starts
        cfg(0, 1, 1, 1);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("idle abort busy", 32'(bus.busy), 32'd0);
        chk("idle abort pulse", 32'(bus.pulse_o), 32'd0);
        chk("idle abort done", 32'(bus.done), 32'd0);
        // zero lengths become one cycle each
        cfg(0, 0, 0, 3);
        bus.start = 1'b1;
        for (int n = 0; n <= 6; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_train("t4", n, 0, 1, 1, 3);
        end
        // start on the done cycle is accepted
        cfg(0, 1, 1, 1);
        bus.start = 1'b1;
        for (int n = 0; n <= 2; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_train("t4b", n, 0, 1, 1, 1);
        end
        // abort during third HIGH, then a fresh train
        cfg(1, 3, 2, 5);
        bus.start = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_train("t5", n, 1, 3, 2, 5);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t5 abort pulse", 32'(bus.pulse_o), 32'd0);
        chk("t5 abort busy", 32'(bus.busy), 32'd0);
        chk("t5 abort idx", 32'(bus.rep_idx), 32'd0);
        chk("t5 abort done", 32'(bus.done), 32'd0);
        cfg(0, 2, 1, 1);
        bus.start = 1'b1;
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_train("t5b", n, 0, 2, 1, 1);
        end
        // async reset mid-HIGH, start held during reset ignored
        cfg(0, 10, 1, 2);
        bus.start = 1'b1;
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_train("t6", n, 0, 10, 1, 2);
        end
        #1 reset = 1'b1;
        bus.start = 1'b1;
        #1 chk_zero("t6 async");
        @(negedge clk);
        chk_zero("t6 held1");
        @(negedge clk);
        chk_zero("t6 held2");
        reset = 1'b0;
        cfg(1, 1, 1, 1);
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_train("t6b", n, 1, 1, 1, 1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
